// File: rtl/dvsd_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dvsd_div_pkg
// Brief    : Shared widths and FSM state encoding for the dvsd_1608d divider.
// Revision : 1.0
// ============================================================================
package dvsd_div_pkg;

    localparam int c_N_W = 16;
    localparam int c_D_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage : dvsd_div_pkg
`default_nettype wire

// File: rtl/dvsd_div_step.sv
`default_nettype none
// ============================================================================
// Module   : dvsd_div_step
// Brief    : One radix-2 restoring division iteration (shift, compare, subtract).
// Revision : 1.0
// ============================================================================
module dvsd_div_step #(
    parameter int D_W = 8
) (
    input  logic [D_W-1:0] rem,
    input  logic           next_bit,
    input  logic [D_W-1:0] divisor,
    output logic [D_W-1:0] rem_next,
    output logic           q_bit
);

    logic [D_W:0]   w_partial;
    logic [D_W-1:0] w_diff;

    assign w_partial = {rem, next_bit};
    // Low bits suffice: whenever we subtract, the true difference is < divisor.
    assign w_diff    = w_partial[D_W-1:0] - divisor;

    always_comb begin
        q_bit    = (w_partial >= {1'b0, divisor});
        rem_next = q_bit ? w_diff : w_partial[D_W-1:0];
    end

endmodule : dvsd_div_step
`default_nettype wire

// File: rtl/dvsd_1608d.sv
`default_nettype none
// ============================================================================
// Module   : dvsd_1608d
// Brief    : Sequential unsigned N_W / D_W restoring divider, one bit per clock.
// Revision : 1.0
// ============================================================================
module dvsd_1608d
    import dvsd_div_pkg::*;
#(
    parameter int N_W = c_N_W,
    parameter int D_W = c_D_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder,
    output logic           div_by_zero
);

    localparam int               CNT_W  = $clog2(N_W) + 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N_W - 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N_W-1:0]   r_num;
    logic [D_W-1:0]   r_div;
    logic [N_W-1:0]   r_quot;
    logic [D_W-1:0]   r_rem;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    logic [D_W-1:0]   w_rem_next;
    logic             w_q_bit;

    dvsd_div_step #(
        .D_W (D_W)
    ) u_step (
        .rem      (r_rem),
        .next_bit (r_num[N_W-1]),
        .divisor  (r_div),
        .rem_next (w_rem_next),
        .q_bit    (w_q_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_num   <= '0;
            r_div   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_num   <= dividend;
                        r_div   <= divisor;
                        r_quot  <= '0;
                        r_rem   <= '0;
                        r_dbz   <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_CALC;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (r_div == '0) begin
                        // Divide-by-zero resolves on the first CALC edge, operand still unshifted.
                        r_quot  <= '1;
                        r_rem   <= r_num[D_W-1:0];
                        r_dbz   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_num  <= r_num << 1;
                        r_rem  <= w_rem_next;
                        r_quot <= {r_quot[N_W-2:0], w_q_bit};
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule : dvsd_1608d
`default_nettype wire

// File: doc/dvsd_1608d.md
DVSD_1608D -- requirements
Module: dvsd_1608d

Interface
REQ-001 Parameter N_W, default 16, dividend and quotient width.
REQ-002 Parameter D_W, default 8, divisor and remainder width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 start  input  1  request; samples dividend/divisor when the block is not busy.
REQ-006 dividend  input  N_W  unsigned dividend.
REQ-007 divisor  input  D_W  unsigned divisor.
REQ-008 busy  output  1  division in progress; start ignored while high.
REQ-009 done  output  1  one-cycle pulse; quotient, remainder and div_by_zero valid.
REQ-010 quotient  output  N_W  unsigned quotient, held until the next accepted start.
REQ-011 remainder  output  D_W  unsigned remainder, held until the next accepted start.
REQ-012 div_by_zero  output  1  last result came from divisor==0, held with results.

Function
REQ-013 Block SHALL compute unsigned quotient=floor(dividend/divisor) and remainder=dividend mod divisor, the inverse of the 8x8->16 multiplier.
REQ-014 FSM SHALL have three states: IDLE, CALC, DONE.
REQ-015 In IDLE or DONE, start=1 at edge E0 SHALL latch operands, clear quotient/remainder/div_by_zero, set busy=1 and enter CALC; otherwise IDLE/DONE SHALL move to IDLE with results held.
REQ-016 CALC SHALL be radix-2 restoring: per edge, partial remainder (D_W+1 bits) = {rem, next dividend bit MSB-first}; if >= divisor, subtract it and shift in quotient bit 1, else shift in 0.
REQ-017 CALC SHALL take exactly N_W edges (E1..E16); at E16 the block SHALL enter DONE with done=1, busy=0 and final results on the outputs.
REQ-018 done SHALL be high for exactly one cycle per accepted start.
REQ-019 divisor==0 at E0 SHALL skip CALC: at E1 enter DONE, done=1, busy=0, quotient=all ones, remainder=dividend[D_W-1:0], div_by_zero=1.
REQ-020 start while busy=1 SHALL be ignored; operands SHALL NOT be re-sampled.
REQ-021 start=1 in the DONE cycle SHALL be accepted (back-to-back), giving done at E16 of the new operation.
REQ-022 Operand inputs SHALL be don't-care except at the accepting edge.
REQ-023 The partial remainder SHALL never overflow D_W+1 bits; the final remainder SHALL be < divisor.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-025 Reset mid-CALC SHALL abort the operation with no done pulse; start is ignored while rst_n=0.
REQ-026 The first start SHALL be accepted at the first edge with rst_n=1.

Structure
REQ-027 Shared package dvsd_div_pkg SHALL hold the N_W/D_W default constants and the FSM state encoding (IDLE, CALC, DONE).
REQ-028 One combinational sub-module dvsd_div_step SHALL perform the shift/compare/subtract of one iteration; the top SHALL hold the FSM, the 5-bit iteration counter and the registers.

Verification
REQ-029 dividend=50000, divisor=200, start at E0 -> busy E0..E16, done only at E16, quotient=250, remainder=0, div_by_zero=0.
REQ-030 dividend=1000, divisor=7 -> quotient=142, remainder=6; dividend=65535, divisor=1 -> quotient=65535, remainder=0.
REQ-031 dividend=0x1234, divisor=0 -> done at E1, quotient=0xFFFF, remainder=0x34, div_by_zero=1.
REQ-032 start with 100/3 at E0, then start with 9/9 at E5 -> second ignored; at E16 quotient=33, remainder=1.
REQ-033 start at E0, rst_n=0 at E8 -> at E8 busy=0, done=0, outputs=0; no done follows; next start after reset completes normally.
REQ-034 start 255/16 held high through the DONE cycle of the previous operation -> accepted back-to-back; done 16 edges later, quotient=15, remainder=15.
